button_debounce: RTL
====================

// Module: button_debounce
// PURPOSE
//  Conditions raw push-button inputs before they reach the button PIO's in_port.
//  Each bit is synchronised to clk with a 2-flop synchroniser, then debounced by
//  its own stable-time counter FSM. The block outputs clean active-high levels
//  plus one-cycle press/release pulses, so the PIO's edge capture sees exactly one
//  edge per physical press or release.
// PARAMETERS
//  WIDTH           4       number of button channels
//  ACTIVE_LOW      1       1: raw input 0 = pressed (board default); 0: raw 1 = pressed
//  DEBOUNCE_CYCLES 500000  consecutive stable samples needed to accept a change (10 ms @ 50 MHz); >= 2
//  CNT_WIDTH       20      counter width; must satisfy 2**CNT_WIDTH > DEBOUNCE_CYCLES
// PORTS
//  clk            in   1      system clock
//  reset_n        in   1      asynchronous active-low reset
//  button_raw     in   WIDTH  raw pad inputs, asynchronous to clk, bouncing
//  debounced      out  WIDTH  clean level, 1 = pressed; drives PIO in_port
//  press_pulse    out  WIDTH  1-cycle strobe when debounced bit goes 0->1
//  release_pulse  out  WIDTH  1-cycle strobe when debounced bit goes 1->0
// BEHAVIOUR
//  Reset (async assert, sync-released by the system reset tree):
//   - sync flops = released level
//   - debounced = 0, press_pulse = 0, release_pulse = 0
//   - all FSMs in STABLE, all counters 0
//  Sync:
//   - s1 <= button_raw ^ {WIDTH{ACTIVE_LOW}}; s2 <= s1
//   - only s2 feeds the FSM
//  Per-bit FSM, states STABLE and COUNTING, with counter cnt[CNT_WIDTH-1:0]:
//   - STABLE, s2 == debounced: hold; cnt = 0
//   - STABLE, s2 != debounced: -> COUNTING, cnt = 1
//   - COUNTING, s2 == debounced (bounce back): -> STABLE, cnt = 0; no output change
//   - COUNTING, s2 != debounced, cnt < DEBOUNCE_CYCLES-1: cnt = cnt+1
//   - COUNTING, s2 != debounced, cnt == DEBOUNCE_CYCLES-1:
//     debounced <= s2; matching pulse = 1 for this one cycle; -> STABLE, cnt = 0
//  Timing and outputs:
//   - debounced changes on the clock edge that takes the DEBOUNCE_CYCLES-th
//     consecutive differing s2 sample.
//   - Latency: raw edge sampled into s1 at edge k -> debounced and pulse update
//     at edge k+DEBOUNCE_CYCLES+1.
//   - Pulses are registered, high for exactly one cycle, and coincide with the
//     debounced transition.
//   - press_pulse and release_pulse are never high together on the same bit.
//  Boundaries and corner cases:
//   - Any single differing-sample glitch shorter than DEBOUNCE_CYCLES restarts
//     the count and is fully rejected.
//   - The counter never wraps: the maximum value reached is DEBOUNCE_CYCLES-1.
//   - Channels are independent. Simultaneous transitions on several bits give
//     simultaneous pulses.
//   - Reset asserted mid-count: the count is discarded and debounced returns to 0.
//     A button still held at reset release produces a press after the full
//     debounce time.
//  Design rule:
//   - No combinational path from button_raw to any output.
// TESTING (bench uses DEBOUNCE_CYCLES=8, ACTIVE_LOW=1, WIDTH=4)
//  1 Reset, button_raw=4'hF held -> debounced=0, both pulse buses 0, for 50 cycles.
//  2 Clean press: bit0 to 0 at edge k, held -> debounced=4'h1 and press_pulse=4'h1
//    at edge k+9; press_pulse back to 0 at k+10.
//  3 Bounce: bit1 toggles 0/1 every 3 cycles for 40 cycles, then holds 0 ->
//    no change during the bounce; a single press_pulse[1] 9 edges after the hold
//    starts.
//  4 Release: from scenario 2 state, bit0 to 1 -> release_pulse=4'h1 for one
//    cycle and debounced=0, 9 edges later.
//  5 Simultaneous: bits2,3 to 0 on the same edge -> press_pulse=4'hC in a single
//    cycle; debounced=4'hC.
//  6 Reset mid-count: bit0 to 0, reset_n low at count 5 for 2 cycles, bit0 still
//    0 -> debounced=0 during reset; press_pulse[0] 9 edges after reset release.

Source files
------------

// File: rtl/button_debounce_if.sv
// Button conditioning bus: raw pad levels in, clean levels and edge strobes out.
interface button_debounce_if #(
    parameter int WIDTH = 4
);
    logic [WIDTH-1:0] button_raw;
    logic [WIDTH-1:0] debounced;
    logic [WIDTH-1:0] press_pulse;
    logic [WIDTH-1:0] release_pulse;

    modport master (output button_raw, input debounced, press_pulse, release_pulse);
    modport slave  (input button_raw, output debounced, press_pulse, release_pulse);
endinterface

// File: rtl/button_debounce.sv
// Push-button conditioner: 2-flop synchroniser per channel, then a per-channel
// stable-time FSM producing a clean level plus one-cycle press/release strobes.
module button_debounce_lane #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic clk,
    input  logic rst_n,
    input  logic s2_i,
    output logic deb_o,
    output logic press_o,
    output logic rel_o
);
    typedef enum logic {STABLE, COUNTING} state_t;

    localparam logic [CNT_WIDTH-1:0] LAST = CNT_WIDTH'(DEBOUNCE_CYCLES - 1);

    state_t               state_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 deb_q, press_q, rel_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= STABLE;
            cnt_q   <= '0;
            deb_q   <= 1'b0;
            press_q <= 1'b0;
            rel_q   <= 1'b0;
        end else begin
            press_q <= 1'b0;
            rel_q   <= 1'b0;
            case (state_q)
                STABLE: begin
                    if (s2_i != deb_q) begin
                        state_q <= COUNTING;
                        cnt_q   <= CNT_WIDTH'(1);
                    end else begin
                        cnt_q   <= '0;
                    end
                end
                COUNTING: begin
                    if (s2_i == deb_q) begin
                        // Bounced back before the window closed: discard the count.
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else if (cnt_q == LAST) begin
                        deb_q   <= s2_i;
                        press_q <= s2_i;
                        rel_q   <= ~s2_i;
                        state_q <= STABLE;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q   <= cnt_q + CNT_WIDTH'(1);
                    end
                end
                default: begin
                    state_q <= STABLE;
                    cnt_q   <= '0;
                end
            endcase
        end
    end

    assign deb_o   = deb_q;
    assign press_o = press_q;
    assign rel_o   = rel_q;
endmodule

module button_debounce #(
    parameter int WIDTH           = 4,
    parameter bit ACTIVE_LOW      = 1'b1,
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_WIDTH       = 20
) (
    input  logic               clk,
    input  logic               reset_n,
    button_debounce_if.slave   bus
);
    // Sync flops hold the pressed-polarity level, so reset (0) means released.
    logic [WIDTH-1:0] s1_q, s2_q;
    logic [WIDTH-1:0] deb, press, rel;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_q <= '0;
            s2_q <= '0;
        end else begin
            s1_q <= bus.button_raw ^ {WIDTH{ACTIVE_LOW}};
            s2_q <= s1_q;
        end
    end

    for (genvar g = 0; g < WIDTH; g++) begin : g_lane
        button_debounce_lane #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_WIDTH      (CNT_WIDTH)
        ) u_lane (
            .clk    (clk),
            .rst_n  (reset_n),
            .s2_i   (s2_q[g]),
            .deb_o  (deb[g]),
            .press_o(press[g]),
            .rel_o  (rel[g])
        );
    end

    assign bus.debounced     = deb;
    assign bus.press_pulse   = press;
    assign bus.release_pulse = rel;
endmodule
